mipi_idelay_cal_ctrl: RTL and testbench

- Per-lane IDELAYE3 tap calibration sequencer for the MIPI D-PHY HS receive path; runs on the ISERDESE3 byte clock.
- On request, sweeps all lanes' IDELAY taps together in VAR_LOAD mode.
- At each tap, checks the deserialized bytes against the deskew training pattern (alternating 0x55/0xAA).
- Per lane, finds the longest passing tap window, loads its centre tap, then returns IDELAY to VT-compensated mode.

---
 rtl/mipi_cal_pkg.sv | 20 ++
 rtl/mipi_cal_window_track.sv | 103 ++++++++++
 rtl/mipi_idelay_cal_ctrl.sv | 221 ++++++++++++++++++++++
 tb/tb_mipi_idelay_cal_ctrl.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/mipi_cal_pkg.sv
// Shared types and defaults for the MIPI D-PHY IDELAY calibration sequencer.
package mipi_cal_pkg;

  localparam int         DEF_TAP_W = 9;
  localparam logic [7:0] DEF_PAT_A = 8'h55;
  localparam logic [7:0] DEF_PAT_B = 8'hAA;

  typedef enum logic [3:0] {
    ST_IDLE         = 4'd0,
    ST_WAIT_RDY     = 4'd1,
    ST_LOAD         = 4'd2,
    ST_SETTLE       = 4'd3,
    ST_CHECK        = 4'd4,
    ST_NEXT         = 4'd5,
    ST_FINAL_LOAD   = 4'd6,
    ST_FINAL_SETTLE = 4'd7,
    ST_DONE         = 4'd8
  } cal_state_e;

endpackage

// File: rtl/mipi_cal_window_track.sv
// Per-lane longest-passing-window tracker; outputs reflect the update of the current step.
module mipi_cal_window_track
  import mipi_cal_pkg::*;
#(
  parameter int TAP_W    = DEF_TAP_W,
  parameter int MAX_TAP  = 511,
  parameter int TAP_STEP = 8,
  parameter int LEN_W    = 7
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             clr,
  input  logic             step,
  input  logic             pass,
  input  logic             last,
  input  logic [TAP_W-1:0] tap,
  output logic [LEN_W-1:0] best_len,
  output logic [TAP_W-1:0] centre
);

  localparam logic [LEN_W-1:0] LEN_ONE  = LEN_W'(1);
  localparam logic [TAP_W:0]   ONE_EXT  = (TAP_W+1)'(1);
  localparam logic [TAP_W:0]   STEP_EXT = (TAP_W+1)'(TAP_STEP);
  localparam logic [TAP_W:0]   MAX_EXT  = (TAP_W+1)'(MAX_TAP);

  logic [TAP_W-1:0] cur_start_r, cur_start_nx, best_start_r, best_start_nx;
  logic [LEN_W-1:0] cur_len_r, cur_len_nx, best_len_r, best_len_nx;
  logic [TAP_W:0]   span_s, centre_ext_s;

  // Window update for one sweep step, including closing an open window on the last step
  always_comb begin
    cur_start_nx  = cur_start_r;
    cur_len_nx    = cur_len_r;
    best_start_nx = best_start_r;
    best_len_nx   = best_len_r;
    if (clr) begin
      cur_start_nx  = {TAP_W{1'b0}};
      cur_len_nx    = {LEN_W{1'b0}};
      best_start_nx = {TAP_W{1'b0}};
      best_len_nx   = {LEN_W{1'b0}};
    end else if (step) begin
      if (pass) begin
        if (cur_len_r == {LEN_W{1'b0}}) begin
          cur_start_nx = tap;
        end else begin
          cur_start_nx = cur_start_r;
        end
        cur_len_nx = cur_len_r + LEN_ONE;
      end else begin
        // Strict compare keeps the earliest of equal-length windows
        if (cur_len_r > best_len_r) begin
          best_start_nx = cur_start_r;
          best_len_nx   = cur_len_r;
        end else begin
          best_len_nx = best_len_r;
        end
        cur_len_nx = {LEN_W{1'b0}};
      end
      if (last) begin
        if (cur_len_nx > best_len_nx) begin
          best_start_nx = cur_start_nx;
          best_len_nx   = cur_len_nx;
        end else begin
          best_len_nx = best_len_nx;
        end
        cur_len_nx = {LEN_W{1'b0}};
      end else begin
        cur_len_nx = cur_len_nx;
      end
    end else begin
      cur_len_nx = cur_len_r;
    end
  end

  // Centre tap of the best window, clamped to the sweep range
  always_comb begin
    span_s       = ((TAP_W+1)'(best_len_nx) - ONE_EXT) * STEP_EXT;
    centre_ext_s = (TAP_W+1)'(best_start_nx) + (span_s >> 1);
    if (centre_ext_s > MAX_EXT) begin
      centre = MAX_EXT[TAP_W-1:0];
    end else begin
      centre = centre_ext_s[TAP_W-1:0];
    end
  end

  assign best_len = best_len_nx;

  // Tracker state registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cur_start_r  <= {TAP_W{1'b0}};
      cur_len_r    <= {LEN_W{1'b0}};
      best_start_r <= {TAP_W{1'b0}};
      best_len_r   <= {LEN_W{1'b0}};
    end else begin
      cur_start_r  <= cur_start_nx;
      cur_len_r    <= cur_len_nx;
      best_start_r <= best_start_nx;
      best_len_r   <= best_len_nx;
    end
  end

endmodule

// File: rtl/mipi_idelay_cal_ctrl.sv
// IDELAYE3 tap sweep sequencer: finds the longest deskew-pattern window per lane and
// loads its centre tap before handing the delay line back to VT compensation.
module mipi_idelay_cal_ctrl
  import mipi_cal_pkg::*;
#(
  parameter int         NUM_LANES  = 2,
  parameter int         TAP_W      = DEF_TAP_W,
  parameter int         MAX_TAP    = 511,
  parameter int         TAP_STEP   = 8,
  parameter int         SETTLE_CYC = 16,
  parameter int         DWELL_CYC  = 64,
  parameter int         MIN_WIN    = 4,
  parameter logic [7:0] PAT_A      = DEF_PAT_A,
  parameter logic [7:0] PAT_B      = DEF_PAT_B
) (
  input  logic                       mipi_byte_clk,
  input  logic                       resetn,
  input  logic                       cal_start,
  input  logic                       idelay_rdy,
  input  logic [NUM_LANES*8-1:0]     lane_byte_data,
  output logic [NUM_LANES*TAP_W-1:0] dly_cntvalue,
  output logic                       dly_load,
  output logic                       dly_en_vtc,
  output logic                       cal_busy,
  output logic                       cal_done,
  output logic [NUM_LANES-1:0]       cal_fail,
  output logic [NUM_LANES*TAP_W-1:0] cal_tap
);

  localparam int CNT_MAX = (SETTLE_CYC > DWELL_CYC) ? SETTLE_CYC : DWELL_CYC;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int LEN_W   = $clog2(MAX_TAP / TAP_STEP + 2);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0] DWELL_LAST  = CNT_W'(DWELL_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
  localparam logic [TAP_W:0]   STEP_EXT    = (TAP_W+1)'(TAP_STEP);
  localparam logic [TAP_W:0]   MAX_EXT     = (TAP_W+1)'(MAX_TAP);
  localparam logic [LEN_W-1:0] MIN_LEN     = LEN_W'(MIN_WIN);

  cal_state_e                 state_r, state_nx;
  logic [TAP_W:0]             tap_r, tap_nx, tap_sum_s;
  logic [CNT_W-1:0]           cnt_r, cnt_nx;
  logic [NUM_LANES*8-1:0]     data_r;
  logic [NUM_LANES-1:0]       pass_r, pass_nx, fail_r, fail_nx;
  logic [NUM_LANES*TAP_W-1:0] cntvalue_r, cntvalue_nx, cal_tap_r, cal_tap_nx;
  logic                       load_r, load_nx, en_vtc_r, en_vtc_nx;
  logic                       busy_r, busy_nx, done_r, done_nx;
  logic                       clr_s, step_s, last_s;
  logic [LEN_W-1:0]           best_len_s [NUM_LANES];
  logic [TAP_W-1:0]           centre_s   [NUM_LANES];

  assign tap_sum_s = tap_r + STEP_EXT;
  assign last_s    = (tap_sum_s > MAX_EXT);

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    mipi_cal_window_track #(
      .TAP_W   (TAP_W),
      .MAX_TAP (MAX_TAP),
      .TAP_STEP(TAP_STEP),
      .LEN_W   (LEN_W)
    ) u_track (
      .clk     (mipi_byte_clk),
      .resetn  (resetn),
      .clr     (clr_s),
      .step    (step_s),
      .pass    (pass_r[g]),
      .last    (last_s),
      .tap     (tap_r[TAP_W-1:0]),
      .best_len(best_len_s[g]),
      .centre  (centre_s[g])
    );
  end

  // Next-state and next-output logic of the sweep sequencer
  always_comb begin
    state_nx    = state_r;
    tap_nx      = tap_r;
    cnt_nx      = cnt_r;
    pass_nx     = pass_r;
    cntvalue_nx = cntvalue_r;
    load_nx     = 1'b0;
    en_vtc_nx   = en_vtc_r;
    busy_nx     = busy_r;
    done_nx     = done_r;
    fail_nx     = fail_r;
    cal_tap_nx  = cal_tap_r;
    clr_s       = 1'b0;
    step_s      = 1'b0;
    case (state_r)
      ST_IDLE, ST_DONE: begin
        if (cal_start) begin
          state_nx  = ST_WAIT_RDY;
          tap_nx    = {(TAP_W+1){1'b0}};
          busy_nx   = 1'b1;
          en_vtc_nx = 1'b0;
          done_nx   = 1'b0;
          fail_nx   = {NUM_LANES{1'b0}};
          clr_s     = 1'b1;
        end else begin
          state_nx = state_r;
        end
      end
      ST_WAIT_RDY: begin
        if (idelay_rdy) begin
          state_nx    = ST_LOAD;
          load_nx     = 1'b1;
          cntvalue_nx = {NUM_LANES{tap_r[TAP_W-1:0]}};
        end else begin
          state_nx = ST_WAIT_RDY;
        end
      end
      ST_LOAD: begin
        state_nx = ST_SETTLE;
        cnt_nx   = {CNT_W{1'b0}};
      end
      ST_SETTLE: begin
        if (cnt_r == SETTLE_LAST) begin
          state_nx = ST_CHECK;
          cnt_nx   = {CNT_W{1'b0}};
          pass_nx  = {NUM_LANES{1'b1}};
        end else begin
          cnt_nx = cnt_r + CNT_ONE;
        end
      end
      ST_CHECK: begin
        for (int i = 0; i < NUM_LANES; i++) begin
          if ((data_r[8*i +: 8] != PAT_A) && (data_r[8*i +: 8] != PAT_B)) begin
            pass_nx[i] = 1'b0;
          end else begin
            pass_nx[i] = pass_r[i];
          end
        end
        if (cnt_r == DWELL_LAST) begin
          state_nx = ST_NEXT;
          cnt_nx   = {CNT_W{1'b0}};
        end else begin
          cnt_nx = cnt_r + CNT_ONE;
        end
      end
      ST_NEXT: begin
        step_s  = 1'b1;
        load_nx = 1'b1;
        if (last_s) begin
          // Tracker outputs already include this final step
          state_nx = ST_FINAL_LOAD;
          for (int i = 0; i < NUM_LANES; i++) begin
            if (best_len_s[i] < MIN_LEN) begin
              fail_nx[i]                     = 1'b1;
              cntvalue_nx[i*TAP_W +: TAP_W]  = {TAP_W{1'b0}};
            end else begin
              fail_nx[i]                     = 1'b0;
              cntvalue_nx[i*TAP_W +: TAP_W]  = centre_s[i];
            end
          end
          cal_tap_nx = cntvalue_nx;
        end else begin
          state_nx    = ST_LOAD;
          tap_nx      = tap_sum_s;
          cntvalue_nx = {NUM_LANES{tap_sum_s[TAP_W-1:0]}};
        end
      end
      ST_FINAL_LOAD: begin
        state_nx = ST_FINAL_SETTLE;
        cnt_nx   = {CNT_W{1'b0}};
      end
      ST_FINAL_SETTLE: begin
        if (cnt_r == SETTLE_LAST) begin
          state_nx  = ST_DONE;
          en_vtc_nx = 1'b1;
          busy_nx   = 1'b0;
          done_nx   = 1'b1;
        end else begin
          cnt_nx = cnt_r + CNT_ONE;
        end
      end
      default: begin
        state_nx = ST_IDLE;
      end
    endcase
  end

  // Sequencer state, input capture and registered outputs
  always_ff @(posedge mipi_byte_clk or negedge resetn) begin
    if (!resetn) begin
      state_r    <= ST_IDLE;
      tap_r      <= {(TAP_W+1){1'b0}};
      cnt_r      <= {CNT_W{1'b0}};
      data_r     <= {(NUM_LANES*8){1'b0}};
      pass_r     <= {NUM_LANES{1'b0}};
      cntvalue_r <= {(NUM_LANES*TAP_W){1'b0}};
      load_r     <= 1'b0;
      en_vtc_r   <= 1'b1;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      fail_r     <= {NUM_LANES{1'b0}};
      cal_tap_r  <= {(NUM_LANES*TAP_W){1'b0}};
    end else begin
      state_r    <= state_nx;
      tap_r      <= tap_nx;
      cnt_r      <= cnt_nx;
      data_r     <= lane_byte_data;
      pass_r     <= pass_nx;
      cntvalue_r <= cntvalue_nx;
      load_r     <= load_nx;
      en_vtc_r   <= en_vtc_nx;
      busy_r     <= busy_nx;
      done_r     <= done_nx;
      fail_r     <= fail_nx;
      cal_tap_r  <= cal_tap_nx;
    end
  end

  assign dly_cntvalue = cntvalue_r;
  assign dly_load     = load_r;
  assign dly_en_vtc   = en_vtc_r;
  assign cal_busy     = busy_r;
  assign cal_done     = done_r;
  assign cal_fail     = fail_r;
  assign cal_tap      = cal_tap_r;

endmodule

// File: tb/tb_mipi_idelay_cal_ctrl.sv
// Directed bench for mipi_idelay_cal_ctrl with a behavioural two-lane IDELAY/deskew model.
module tb_mipi_idelay_cal_ctrl;

  logic        clk = 1'b0;
  logic        resetn, cal_start, idelay_rdy;
  logic [15:0] lane_byte_data;
  logic [17:0] dly_cntvalue, cal_tap;
  logic        dly_load, dly_en_vtc, cal_busy, cal_done;
  logic [1:0]  cal_fail;

  int tests = 0;
  int fails = 0;
  int lo_a[2], hi_a[2], lo_b[2], hi_b[2];
  int lane_tap[2] = '{0, 0};
  logic [7:0]  phase = 8'd0;
  int          load_cnt = 0;
  int          vtc_bad = 0;
  logic [17:0] load_q[$];
  int          base, cyc;

  always #5 clk = ~clk;

  mipi_idelay_cal_ctrl dut (
    .mipi_byte_clk (clk),
    .resetn        (resetn),
    .cal_start     (cal_start),
    .idelay_rdy    (idelay_rdy),
    .lane_byte_data(lane_byte_data),
    .dly_cntvalue  (dly_cntvalue),
    .dly_load      (dly_load),
    .dly_en_vtc    (dly_en_vtc),
    .cal_busy      (cal_busy),
    .cal_done      (cal_done),
    .cal_fail      (cal_fail),
    .cal_tap       (cal_tap)
  );

  // Inside the eye: clean 55/AA; outside: same pattern with a corrupt byte every 16 cycles
  function automatic logic [7:0] lane_byte(input int tap, input int la, input int ha,
                                           input int lb, input int hb, input logic [7:0] ph);
    logic good;
    good = ((tap >= la) && (tap <= ha)) || ((tap >= lb) && (tap <= hb));
    if (!good && (ph[3:0] == 4'd0)) return 8'h5A;
    return ph[0] ? 8'hAA : 8'h55;
  endfunction

  assign lane_byte_data[7:0]  = lane_byte(lane_tap[0], lo_a[0], hi_a[0], lo_b[0], hi_b[0], phase);
  assign lane_byte_data[15:8] = lane_byte(lane_tap[1], lo_a[1], hi_a[1], lo_b[1], hi_b[1], phase);

  always @(posedge clk) begin
    phase <= phase + 8'd1;
    if (dly_load) begin
      lane_tap[0] <= int'(dly_cntvalue[8:0]);
      lane_tap[1] <= int'(dly_cntvalue[17:9]);
      load_cnt    <= load_cnt + 1;
      load_q.push_back(dly_cntvalue);
    end
  end

  always @(negedge clk) begin
    if (cal_busy && dly_en_vtc) vtc_bad <= vtc_bad + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic set_win(input int lane, input int la, input int ha, input int lb, input int hb);
    lo_a[lane] = la; hi_a[lane] = ha; lo_b[lane] = lb; hi_b[lane] = hb;
  endtask

  task automatic pulse_start();
    @(negedge clk) cal_start = 1'b1;
    @(negedge clk) cal_start = 1'b0;
  endtask

  // cyc counts rising edges since the one that accepted cal_start
  task automatic wait_done(input int start_cyc, output int n);
    n = start_cyc;
    while (!cal_done && n < 20000) begin
      @(negedge clk);
      n++;
    end
    chk("done_within_budget", 32'(cal_done), 32'd1);
  endtask

  initial begin
    resetn = 1'b0; cal_start = 1'b0; idelay_rdy = 1'b1;
    set_win(0, 0, 511, 1, 0);
    set_win(1, 0, 511, 1, 0);
    repeat (3) @(negedge clk);
    chk("rst_cntvalue", 32'(dly_cntvalue), 32'd0);
    chk("rst_load", 32'(dly_load), 32'd0);
    chk("rst_en_vtc", 32'(dly_en_vtc), 32'd1);
    chk("rst_busy", 32'(cal_busy), 32'd0);
    chk("rst_done", 32'(cal_done), 32'd0);
    chk("rst_fail", 32'(cal_fail), 32'd0);
    chk("rst_tap", 32'(cal_tap), 32'd0);
    resetn = 1'b1;
    repeat (2) @(negedge clk);

    // Full-range eye: window 0..504 (64 steps), centre 252; 2 + 64*82 + 17 = 5267 edges
    base = load_cnt;
    pulse_start();
    chk("a_busy", 32'(cal_busy), 32'd1);
    chk("a_en_vtc_low", 32'(dly_en_vtc), 32'd0);
    wait_done(1, cyc);
    chk("a_latency", 32'(cyc), 32'd5267);
    chk("a_tap0", 32'(cal_tap[8:0]), 32'd252);
    chk("a_tap1", 32'(cal_tap[17:9]), 32'd252);
    chk("a_fail", 32'(cal_fail), 32'd0);
    chk("a_busy_end", 32'(cal_busy), 32'd0);
    chk("a_en_vtc_end", 32'(dly_en_vtc), 32'd1);
    chk("a_loads", 32'(load_cnt - base), 32'd65);

    // Restart from DONE with lane0 eye 80..200 and lane1 eye 300..340; mid-sweep start ignored
    set_win(0, 80, 200, 1, 0);
    set_win(1, 300, 340, 1, 0);
    base = load_cnt;
    pulse_start();
    chk("b_done_drops", 32'(cal_done), 32'd0);
    chk("b_busy", 32'(cal_busy), 32'd1);
    repeat (1000) @(negedge clk);
    cal_start = 1'b1;
    @(negedge clk) cal_start = 1'b0;
    wait_done(1002, cyc);
    chk("b_latency", 32'(cyc), 32'd5267);
    chk("b_loads", 32'(load_cnt - base), 32'd65);
    chk("b_first_load_tap0", 32'(load_q[base]), 32'd0);
    chk("b_last_load", 32'(load_q[load_q.size()-1]), (32'd320 << 9) | 32'd140);
    chk("b_tap0", 32'(cal_tap[8:0]), 32'd140);
    chk("b_tap1", 32'(cal_tap[17:9]), 32'd320);
    chk("b_fail", 32'(cal_fail), 32'd0);

    // Tied windows on lane0 (earliest wins) and a window still open at sweep end on lane1
    set_win(0, 40, 72, 400, 432);
    set_win(1, 480, 504, 1, 0);
    idelay_rdy = 1'b0;
    base = load_cnt;
    pulse_start();
    repeat (50) @(negedge clk);
    chk("c_rdy_no_load", 32'(load_cnt - base), 32'd0);
    chk("c_rdy_busy", 32'(cal_busy), 32'd1);
    chk("c_rdy_load_low", 32'(dly_load), 32'd0);
    idelay_rdy = 1'b1;
    wait_done(51, cyc);
    chk("c_latency", 32'(cyc), 32'd5317);
    chk("c_tap0", 32'(cal_tap[8:0]), 32'd56);
    chk("c_tap1", 32'(cal_tap[17:9]), 32'd492);
    chk("c_fail", 32'(cal_fail), 32'd0);
    chk("c_loads", 32'(load_cnt - base), 32'd65);

    // Lane0 never passes; lane1 passes only 104/112 (2 steps, below MIN_WIN)
    set_win(0, 1, 0, 1, 0);
    set_win(1, 100, 116, 1, 0);
    pulse_start();
    wait_done(1, cyc);
    chk("d_fail", 32'(cal_fail), 32'd3);
    chk("d_tap", 32'(cal_tap), 32'd0);
    chk("d_done", 32'(cal_done), 32'd1);
    chk("d_last_load", 32'(load_q[load_q.size()-1]), 32'd0);

    // Asynchronous reset during the CHECK phase of tap 24
    set_win(0, 0, 511, 1, 0);
    set_win(1, 0, 511, 1, 0);
    pulse_start();
    repeat (3 * 82 + 30) @(negedge clk);
    chk("e_busy_pre", 32'(cal_busy), 32'd1);
    chk("e_cntvalue_pre", 32'(dly_cntvalue), (32'd24 << 9) | 32'd24);
    resetn = 1'b0;
    #1;
    chk("e_rst_cntvalue", 32'(dly_cntvalue), 32'd0);
    chk("e_rst_load", 32'(dly_load), 32'd0);
    chk("e_rst_en_vtc", 32'(dly_en_vtc), 32'd1);
    chk("e_rst_busy", 32'(cal_busy), 32'd0);
    chk("e_rst_done", 32'(cal_done), 32'd0);
    chk("e_rst_fail", 32'(cal_fail), 32'd0);
    chk("e_rst_tap", 32'(cal_tap), 32'd0);
    repeat (3) @(negedge clk);
    chk("e_stays_idle", 32'(cal_busy), 32'd0);
    chk("vtc_low_while_busy", 32'(vtc_bad), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
